button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 131 +++++++++++++
 tb/tb_button_debouncer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: synchronise, debounce, and emit press/release/long-press pulses plus a press count.
// Latency: a clean BTN edge reaches BTN_STATE after 2 + DEBOUNCE_CYCLES clocks, and the pulses follow one clock later; there is no backpressure.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       BTN_STATE,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG_PRESS,
    output logic [7:0] PRESS_COUNT
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic              sync1;
    logic              sync2;
    logic              sample;
    logic [DEB_W-1:0]  deb_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              state_d;
    logic              rise;
    logic              fall;
    logic              long_nxt;
    state_t            state;
    state_t            state_nxt;

    // Synchroniser flops reset to the electrical "released" level of the pin.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    assign sample = sync2 ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            deb_cnt   <= '0;
            BTN_STATE <= 1'b0;
        end else if (sample == BTN_STATE) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            BTN_STATE <= sample;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign rise = BTN_STATE & ~state_d;
    assign fall = ~BTN_STATE & state_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_d     <= 1'b0;
            PRESS       <= 1'b0;
            RELEASE     <= 1'b0;
            PRESS_COUNT <= 8'd0;
        end else begin
            state_d <= BTN_STATE;
            PRESS   <= rise;
            RELEASE <= fall;
            if (rise) begin
                PRESS_COUNT <= PRESS_COUNT + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            LONG_PRESS <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            LONG_PRESS <= long_nxt;
            // Held at zero outside PRESSED so entry always starts from zero; saturates at the terminal value.
            if (state != PRESSED) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        long_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                // A release wins over reaching the long-press threshold in the same cycle.
                if (fall) begin
                    state_nxt = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = HELD;
                    long_nxt  = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low button.
module tb_button_debouncer;

    logic       CLK;
    logic       RST;
    logic       BTN;
    logic       BTN_STATE;
    logic       PRESS;
    logic       RELEASE;
    logic       LONG_PRESS;
    logic [7:0] PRESS_COUNT;

    int n_cmp = 0;
    int n_err = 0;
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int n_both = 0;
    int p0;
    int r0;
    int l0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN        (BTN),
        .BTN_STATE  (BTN_STATE),
        .PRESS      (PRESS),
        .RELEASE    (RELEASE),
        .LONG_PRESS (LONG_PRESS),
        .PRESS_COUNT(PRESS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse tallies: each high cycle of a registered output is counted once.
    always @(posedge CLK) begin
        if (PRESS) n_press++;
        if (RELEASE) n_release++;
        if (LONG_PRESS) n_long++;
        if (PRESS && RELEASE) n_both++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic snap();
        p0 = n_press;
        r0 = n_release;
        l0 = n_long;
    endtask

    initial begin
        RST = 1'b1;
        BTN = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(2);
        check("rst_state", int'(BTN_STATE), 0);
        check("rst_press", int'(PRESS), 0);
        check("rst_release", int'(RELEASE), 0);
        check("rst_long", int'(LONG_PRESS), 0);
        check("rst_count", int'(PRESSED_COUNT_FN()), 0);

        // Clean press: state at edge 6, PRESS at edge 7.
        BTN = 1'b0;
        tick(5);
        check("clean_state_e5", int'(BTN_STATE), 0);
        tick(1);
        check("clean_state_e6", int'(BTN_STATE), 1);
        check("clean_press_e6", int'(PRESS), 0);
        tick(1);
        check("clean_press_e7", int'(PRESS), 1);
        check("clean_count", int'(PRESS_COUNT), 1);
        tick(1);
        check("clean_press_e8", int'(PRESS), 0);
        BTN = 1'b1;
        tick(6);
        check("clean_rel_state", int'(BTN_STATE), 0);
        check("clean_rel_pulse_e6", int'(RELEASE), 0);
        tick(1);
        check("clean_rel_pulse_e7", int'(RELEASE), 1);
        tick(5);

        // Short press: released 10 cycles after debounce.
        snap();
        BTN = 1'b0;
        tick(6);
        tick(10);
        BTN = 1'b1;
        tick(12);
        check("short_press_n", n_press - p0, 1);
        check("short_release_n", n_release - r0, 1);
        check("short_long_n", n_long - l0, 0);
        check("short_count", int'(PRESS_COUNT), 2);

        // Bounce: toggle every 2 cycles for 20 cycles, then hold released.
        snap();
        for (int i = 0; i < 10; i++) begin
            BTN = ~BTN;
            tick(2);
            check("bounce_state", int'(BTN_STATE), 0);
        end
        BTN = 1'b1;
        tick(10);
        check("bounce_state_end", int'(BTN_STATE), 0);
        check("bounce_press_n", n_press - p0, 0);
        check("bounce_release_n", n_release - r0, 0);

        // Long hold: entry to PRESSED at edge 7, LONG_PRESS visible 20 edges later.
        snap();
        BTN = 1'b0;
        tick(7);
        check("long_press_pulse", int'(PRESS), 1);
        tick(19);
        check("long_pulse_e26", int'(LONG_PRESS), 0);
        tick(1);
        check("long_pulse_e27", int'(LONG_PRESS), 1);
        tick(1);
        check("long_pulse_e28", int'(LONG_PRESS), 0);
        tick(18);
        BTN = 1'b1;
        tick(7);
        check("long_rel_pulse", int'(RELEASE), 1);
        tick(5);
        check("long_long_n", n_long - l0, 1);
        check("long_release_n", n_release - r0, 1);
        // A following short press must not inherit HELD state.
        snap();
        BTN = 1'b0;
        tick(12);
        BTN = 1'b1;
        tick(12);
        check("after_long_press_n", n_press - p0, 1);
        check("after_long_long_n", n_long - l0, 0);
        check("after_long_count", int'(PRESS_COUNT), 4);

        // Reset while in PRESSED with the button still held.
        snap();
        BTN = 1'b0;
        tick(10);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        check("midrst_state", int'(BTN_STATE), 0);
        check("midrst_press", int'(PRESS), 0);
        check("midrst_release", int'(RELEASE), 0);
        check("midrst_long", int'(LONG_PRESS), 0);
        check("midrst_count", int'(PRESS_COUNT), 0);
        tick(6);
        check("midrst_state_e6", int'(BTN_STATE), 1);
        check("midrst_press_e6", int'(PRESS), 0);
        tick(1);
        check("midrst_press_e7", int'(PRESS), 1);
        check("midrst_count_e7", int'(PRESS_COUNT), 1);
        check("midrst_release_n", n_release - r0, 0);
        BTN = 1'b1;
        tick(10);

        // Wrap: 256 presses from a freshly reset count.
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(2);
        snap();
        for (int i = 0; i < 256; i++) begin
            BTN = 1'b0;
            tick(8);
            BTN = 1'b1;
            tick(8);
            if (i == 254) check("wrap_count_255", int'(PRESS_COUNT), 255);
        end
        check("wrap_count_0", int'(PRESS_COUNT), 0);
        check("wrap_press_n", n_press - p0, 256);
        check("press_release_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [7:0] PRESSED_COUNT_FN();
        return PRESS_COUNT;
    endfunction

endmodule
